// File: rtl/unidad_fetch_pkg.sv
// Shared types for the instruction-fetch front end:
// FSM state encoding and the prefetch FIFO entry layout.
package pkg_fetch;

  localparam int PKG_DATA_W = 32;
  localparam int PKG_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } estado_fetch_t;

  typedef struct packed {
    logic [PKG_DATA_W-1:0] instr;
    logic [PKG_ADDR_W-1:0] pc;
  } entrada_fifo_t;

endpackage

// File: rtl/unidad_fetch_if.sv
// Fetch unit bus: instruction-memory req/ack side,
// decode valid/ready side, and branch redirect.
interface unidad_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              imemReq;
  logic [ADDR_W-1:0] imemDirec;
  logic              imemAck;
  logic [DATA_W-1:0] imemDato;
  logic              instrValid;
  logic [DATA_W-1:0] instruccion;
  logic [ADDR_W-1:0] instrPC;
  logic              instrReady;
  logic              branchTaken;
  logic [ADDR_W-1:0] branchDirec;
  logic [CNT_W-1:0]  fifoCount;

  modport master (
    output imemReq, imemDirec,
    output instrValid, instruccion, instrPC,
    output fifoCount,
    input  imemAck, imemDato,
    input  instrReady,
    input  branchTaken, branchDirec
  );

  modport slave (
    input  imemReq, imemDirec,
    input  instrValid, instruccion, instrPC,
    input  fifoCount,
    output imemAck, imemDato,
    output instrReady,
    output branchTaken, branchDirec
  );

endinterface

// File: rtl/unidad_fetch_fifo.sv
// Prefetch FIFO: circular buffer, first-word-fall-through
// head, flush overrides push and pop.
module fifo_prefetch #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    cab;
  logic [PW-1:0]    col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cab   <= '0;
      col   <= '0;
      count <= '0;
    end else if (flush) begin
      cab   <= '0;
      col   <= '0;
      count <= '0;
    end else begin
      if (push) col <= col + PW'(1);
      if (pop)  cab <= cab + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[col] <= din;
  end

  assign dout  = mem[cab];
  assign valid = (count != '0);

endmodule

// File: rtl/unidad_fetch.sv
// Instruction-fetch front end: fetch FSM, PC tracking and
// credit-gated issue into the prefetch FIFO.
module unidad_fetch #(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input logic            clk,
  input logic            rst_n,
  unidad_fetch_if.master bus
);

  import pkg_fetch::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = DATA_W + ADDR_W;
  localparam logic [CNT_W-1:0] LLENO = CNT_W'(DEPTH);

  estado_fetch_t     estado;
  logic [ADDR_W-1:0] fetchPC;
  logic [ADDR_W-1:0] imemDirec;
  logic [ADDR_W-1:0] siguientePC;
  logic              imemReq;
  logic              push;
  logic              pop;
  logic              valido;
  logic [CNT_W-1:0]  cuenta;
  logic [CNT_W-1:0]  cuentaTras;
  logic [ENT_W-1:0]  cabeza;

  assign push = (estado == REQ) & bus.imemAck & ~bus.branchTaken;
  assign pop  = valido & bus.instrReady & ~bus.branchTaken;

  assign siguientePC = imemDirec + ADDR_W'(PC_STEP);
  // occupancy after an ack edge; only meaningful when push is set
  assign cuentaTras  = cuenta + CNT_W'(1) - CNT_W'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= IDLE;
      fetchPC   <= RESET_PC;
      imemDirec <= RESET_PC;
      imemReq   <= 1'b0;
    end else if (bus.branchTaken) begin
      fetchPC <= bus.branchDirec;
      unique case (estado)
        IDLE: begin
          estado    <= REQ;
          imemReq   <= 1'b1;
          imemDirec <= bus.branchDirec;
        end
        REQ: begin
          if (bus.imemAck) imemDirec <= bus.branchDirec;
          else             estado    <= DRAIN;
        end
        default: estado <= DRAIN;
      endcase
    end else begin
      unique case (estado)
        IDLE: begin
          if (cuenta < LLENO) begin
            estado    <= REQ;
            imemReq   <= 1'b1;
            imemDirec <= fetchPC;
          end
        end
        REQ: begin
          if (bus.imemAck) begin
            fetchPC <= siguientePC;
            if (cuentaTras < LLENO) begin
              imemDirec <= siguientePC;
            end else begin
              estado  <= IDLE;
              imemReq <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (bus.imemAck) begin
            estado    <= REQ;
            imemDirec <= fetchPC;
          end
        end
        default: begin
          estado  <= IDLE;
          imemReq <= 1'b0;
        end
      endcase
    end
  end

  fifo_prefetch #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.branchTaken),
    .din   ({bus.imemDato, imemDirec}),
    .dout  (cabeza),
    .count (cuenta),
    .valid (valido)
  );

  assign bus.imemReq     = imemReq;
  assign bus.imemDirec   = imemDirec;
  assign bus.instrValid  = valido;
  assign bus.instruccion = cabeza[ENT_W-1 -: DATA_W];
  assign bus.instrPC     = cabeza[ADDR_W-1:0];
  assign bus.fifoCount   = cuenta;

endmodule

// File: tb/tb_unidad_fetch.sv
// Directed bench for unidad_fetch: cycle vector table plus
// hand sequences for branch drain, PC wrap and async reset.
module tb_unidad_fetch;

  localparam logic [31:0] K    = 32'hA5A5A5A5;
  localparam logic [31:0] WPC  = 32'hFFFFFFF8;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        br;
    logic [31:0] bd;
    logic        req;
    logic [31:0] dir;
    logic        val;
    logic [31:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nVec = 0;
  int   nBad = 0;
  int   lat = 0;
  int   espera = 0;

  unidad_fetch_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) bus ();
  unidad_fetch_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) busW ();

  unidad_fetch #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(4),
    .RESET_PC(32'h0), .PC_STEP(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  unidad_fetch #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(4),
    .RESET_PC(WPC), .PC_STEP(4)
  ) dutw (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busW.master)
  );

  always #5 clk = ~clk;

  assign bus.imemDato  = bus.imemDirec ^ K;
  assign busW.imemDato = busW.imemDirec ^ K;

  // memory model: ack in the lat-th cycle of a request
  always @(negedge clk) begin
    if (lat == 0) begin
      bus.imemAck = 1'b1;
      espera = 0;
    end else if (!bus.imemReq) begin
      bus.imemAck = 1'b0;
      espera = 0;
    end else if (espera == lat - 1) begin
      bus.imemAck = 1'b1;
      espera = 0;
    end else begin
      bus.imemAck = 1'b0;
      espera = espera + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chkRow(input int i, input vec_t v);
    logic bad;
    logic [31:0] dat;
    dat = v.pc ^ K;
    bad = (bus.imemReq !== v.req) || (bus.imemDirec !== v.dir) ||
          (bus.instrValid !== v.val) || (bus.fifoCount !== v.cnt);
    if (v.val)
      bad = bad || (bus.instrPC !== v.pc) || (bus.instruccion !== dat);
    nVec++;
    if (bad) begin
      nBad++;
      $display("FAIL row%0d: got req=%b dir=%h val=%b pc=%h dat=%h cnt=%0d want req=%b dir=%h val=%b pc=%h dat=%h cnt=%0d",
               i, bus.imemReq, bus.imemDirec, bus.instrValid, bus.instrPC,
               bus.instruccion, bus.fifoCount, v.req, v.dir, v.val,
               v.pc, dat, v.cnt);
    end
  endtask

  task automatic chkReset(input string nm);
    check({nm, "_req"}, 32'(bus.imemReq), 32'h0);
    check({nm, "_dir"}, bus.imemDirec, 32'h0);
    check({nm, "_val"}, 32'(bus.instrValid), 32'h0);
    check({nm, "_cnt"}, 32'(bus.fifoCount), 32'h0);
    check({nm, "_wdir"}, busW.imemDirec, WPC);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.branchTaken = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chkReset("rst");
  endtask

  function automatic vec_t mk(input logic rst, input logic rdy,
                              input logic br, input logic [31:0] bd,
                              input logic req, input logic [31:0] dir,
                              input logic val, input logic [31:0] pc,
                              input logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.br = br; v.bd = bd;
    v.req = req; v.dir = dir; v.val = val; v.pc = pc; v.cnt = cnt;
    return v;
  endfunction

  vec_t tabla[21];

  initial begin
    logic [31:0] wexp [4];
    int i;
    logic hallado;

    // streaming, ready high
    tabla[0]  = mk(1, 1, 0, 0, 1, 32'h00, 0, 32'h00, 0);
    tabla[1]  = mk(0, 1, 0, 0, 1, 32'h04, 1, 32'h00, 1);
    tabla[2]  = mk(0, 1, 0, 0, 1, 32'h08, 1, 32'h04, 1);
    tabla[3]  = mk(0, 1, 0, 0, 1, 32'h0C, 1, 32'h08, 1);
    tabla[4]  = mk(0, 1, 0, 0, 1, 32'h10, 1, 32'h0C, 1);
    // fill to full, then drain with one idle bubble
    tabla[5]  = mk(1, 0, 0, 0, 1, 32'h00, 0, 32'h00, 0);
    tabla[6]  = mk(0, 0, 0, 0, 1, 32'h04, 1, 32'h00, 1);
    tabla[7]  = mk(0, 0, 0, 0, 1, 32'h08, 1, 32'h00, 2);
    tabla[8]  = mk(0, 0, 0, 0, 1, 32'h0C, 1, 32'h00, 3);
    tabla[9]  = mk(0, 0, 0, 0, 0, 32'h0C, 1, 32'h00, 4);
    tabla[10] = mk(0, 0, 0, 0, 0, 32'h0C, 1, 32'h00, 4);
    tabla[11] = mk(0, 1, 0, 0, 0, 32'h0C, 1, 32'h04, 3);
    tabla[12] = mk(0, 1, 0, 0, 1, 32'h10, 1, 32'h08, 2);
    tabla[13] = mk(0, 1, 0, 0, 1, 32'h14, 1, 32'h0C, 2);
    tabla[14] = mk(0, 1, 0, 0, 1, 32'h18, 1, 32'h10, 2);
    // branch with pop and ack at count 3
    tabla[15] = mk(1, 0, 0, 0, 1, 32'h00, 0, 32'h00, 0);
    tabla[16] = mk(0, 0, 0, 0, 1, 32'h04, 1, 32'h00, 1);
    tabla[17] = mk(0, 0, 0, 0, 1, 32'h08, 1, 32'h00, 2);
    tabla[18] = mk(0, 0, 0, 0, 1, 32'h0C, 1, 32'h00, 3);
    tabla[19] = mk(0, 1, 1, 32'h40, 1, 32'h40, 0, 32'h00, 0);
    tabla[20] = mk(0, 1, 0, 0, 1, 32'h44, 1, 32'h40, 1);

    bus.instrReady  = 1'b1;
    bus.branchTaken = 1'b0;
    bus.branchDirec = '0;
    busW.imemAck     = 1'b1;
    busW.instrReady  = 1'b1;
    busW.branchTaken = 1'b0;
    busW.branchDirec = '0;
    lat = 0;

    for (int k = 0; k < 21; k++) begin
      if (tabla[k].rst) doReset();
      bus.instrReady  = tabla[k].rdy;
      bus.branchTaken = tabla[k].br;
      bus.branchDirec = tabla[k].bd;
      step();
      chkRow(k, tabla[k]);
    end
    bus.branchTaken = 1'b0;

    // PC wrap from RESET_PC near the top of the address space
    wexp[0] = 32'hFFFFFFF8;
    wexp[1] = 32'hFFFFFFFC;
    wexp[2] = 32'h00000000;
    wexp[3] = 32'h00000004;
    doReset();
    step();
    check("wrap_req", 32'(busW.imemReq), 32'h1);
    for (int j = 0; j < 4; j++) begin
      step();
      check("wrap_val", 32'(busW.instrValid), 32'h1);
      check("wrap_pc", busW.instrPC, wexp[j]);
      check("wrap_dat", busW.instruccion, wexp[j] ^ K);
    end

    // branch during an in-flight request, latency 3
    lat = 3;
    bus.instrReady = 1'b1;
    doReset();
    hallado = 1'b0;
    for (i = 0; i < 40 && !hallado; i++) begin
      step();
      hallado = bus.imemReq && (bus.imemDirec == 32'h8);
    end
    check("drain_wait8", 32'(hallado), 32'h1);
    step();
    bus.branchTaken = 1'b1;
    bus.branchDirec = 32'h100;
    step();
    bus.branchTaken = 1'b0;
    check("drain_req", 32'(bus.imemReq), 32'h1);
    check("drain_dir", bus.imemDirec, 32'h8);
    check("drain_cnt", 32'(bus.fifoCount), 32'h0);
    step();
    check("redir_dir", bus.imemDirec, 32'h100);
    check("redir_cnt", 32'(bus.fifoCount), 32'h0);
    check("redir_val", 32'(bus.instrValid), 32'h0);
    hallado = 1'b0;
    for (i = 0; i < 20 && !hallado; i++) begin
      step();
      hallado = bus.instrValid;
    end
    check("redir_wait", 32'(hallado), 32'h1);
    check("redir_pc", bus.instrPC, 32'h100);
    check("redir_dat", bus.instruccion, 32'h100 ^ K);

    // asynchronous reset in the middle of a pending request
    lat = 3;
    bus.instrReady = 1'b0;
    doReset();
    repeat (5) step();
    check("pre_cnt", 32'(bus.fifoCount), 32'h1);
    check("pre_req", 32'(bus.imemReq), 32'h1);
    check("pre_dir", bus.imemDirec, 32'h4);
    #3;
    rst_n = 1'b0;
    lat = 0;
    #1;
    chkReset("arst");
    repeat (2) step();
    chkReset("arst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_req", 32'(bus.imemReq), 32'h1);
    check("post_dir", bus.imemDirec, 32'h0);
    check("post_cnt0", 32'(bus.fifoCount), 32'h0);
    step();
    check("post_pc", bus.instrPC, 32'h0);
    check("post_cnt1", 32'(bus.fifoCount), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
